life_gen_ctrl: RTL and testbench

Parametrised Game-of-Life generation engine. Holds a ROWS x COLS board register, loads a seed, and advances generations under control of a state machine. Supported modes: free-run, single-step, bounded run (max_gens), and automatic halt on a stable or extinct board. Drives the board to the display path and exposes a generation counter and status flags to the top-level controller.

---
 rtl/life_pkg.sv | 24 ++
 rtl/life_next.sv | 61 ++++++
 rtl/life_gen_ctrl.sv | 157 +++++++++++++++
 tb/tb_life_gen_ctrl.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/life_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : life_pkg
//  Description : Shared types and helpers for the Game-of-Life engine.
//                - state_t  : controller states IDLE / RUN / STEP / HALT
//                - cell_idx : flat bit index of cell (row r, col c)
//  Revision    : 1.0  initial release
// ============================================================================
package life_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        STEP = 2'd2,
        HALT = 2'd3
    } state_t;

    // Board bit r*COLS+c holds cell (row r, col c).
    function automatic int cell_idx(input int r, input int c, input int cols);
        return r * cols + c;
    endfunction

endpackage
`default_nettype wire

// File: rtl/life_next.sv
`default_nettype none
// ============================================================================
//  Module      : life_next
//  Description : Combinational Game-of-Life generation step, rule B3/S23.
//                WRAP=0 treats cells beyond the edge as dead, WRAP=1 makes
//                the board a torus.
//  Ports       : i_board  current board (ROWS*COLS bits)
//                o_next   board of the following generation
//  Revision    : 1.0  initial release
// ============================================================================
module life_next
    import life_pkg::*;
#(
    parameter int ROWS = 8,
    parameter int COLS = 8,
    parameter int WRAP = 0
) (
    input  logic [ROWS*COLS-1:0] i_board,
    output logic [ROWS*COLS-1:0] o_next
);

    localparam int C_CELLS = ROWS * COLS;

    // Count live neighbours of (r, c); at most 8 so 4 bits suffice.
    function automatic logic [3:0] neighbours(input logic [C_CELLS-1:0] b,
                                              input int r, input int c);
        logic [3:0] n;
        int         rr;
        int         cc;
        n = 4'd0;
        for (int dr = -1; dr <= 1; dr++) begin
            for (int dc = -1; dc <= 1; dc++) begin
                if (dr != 0 || dc != 0) begin
                    rr = r + dr;
                    cc = c + dc;
                    if (WRAP != 0) begin
                        rr = (rr + ROWS) % ROWS;
                        cc = (cc + COLS) % COLS;
                    end
                    if (rr >= 0 && rr < ROWS && cc >= 0 && cc < COLS) begin
                        // Shift-and-mask avoids a wide variable bit-select.
                        n = n + 4'((b >> cell_idx(rr, cc, COLS)) & C_CELLS'(1));
                    end
                end
            end
        end
        return n;
    endfunction

    for (genvar r = 0; r < ROWS; r++) begin : g_row
        for (genvar c = 0; c < COLS; c++) begin : g_col
            localparam int C_IDX = r * COLS + c;
            logic [3:0] w_n;
            assign w_n = neighbours(i_board, r, c);
            // Born with exactly 3, survives with 2 or 3.
            assign o_next[C_IDX] = (w_n == 4'd3) || ((w_n == 4'd2) && i_board[C_IDX]);
        end
    end

endmodule
`default_nettype wire

// File: rtl/life_gen_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : life_gen_ctrl
//  Description : Game-of-Life generation engine: board register, seed load,
//                free-run / single-step / bounded run, automatic halt on a
//                stable or extinct board.
//  Ports       : clk, reset (async, active-high)
//                clear, load, seed, start, step, stop, max_gens (controls)
//                gout (board), gen_count (saturating), busy, done (pulse),
//                stable, extinct (sticky flags)
//  Revision    : 1.0  initial release
// ============================================================================
module life_gen_ctrl
    import life_pkg::*;
#(
    parameter int ROWS = 8,
    parameter int COLS = 8,
    parameter int GENW = 16,
    parameter int WRAP = 0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 clear,
    input  logic                 load,
    input  logic [ROWS*COLS-1:0] seed,
    input  logic                 start,
    input  logic                 step,
    input  logic                 stop,
    input  logic [GENW-1:0]      max_gens,
    output logic [ROWS*COLS-1:0] gout,
    output logic [GENW-1:0]      gen_count,
    output logic                 busy,
    output logic                 done,
    output logic                 stable,
    output logic                 extinct
);

    localparam int C_CELLS = ROWS * COLS;

    state_t             r_state,   w_state_nx;
    logic [C_CELLS-1:0] r_board,   w_board_nx;
    logic [GENW-1:0]    r_cnt,     w_cnt_nx;
    logic               r_stable,  w_stable_nx;
    logic               r_extinct, w_extinct_nx;
    logic               r_done,    w_done_nx;

    logic [C_CELLS-1:0] w_next;
    logic [GENW-1:0]    w_cnt_inc;
    logic               w_adv;

    life_next #(
        .ROWS (ROWS),
        .COLS (COLS),
        .WRAP (WRAP)
    ) u_next (
        .i_board (r_board),
        .o_next  (w_next)
    );

    assign w_cnt_inc = (&r_cnt) ? r_cnt : r_cnt + GENW'(1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= IDLE;
            r_board   <= '0;
            r_cnt     <= '0;
            r_stable  <= 1'b0;
            r_extinct <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_state_nx;
            r_board   <= w_board_nx;
            r_cnt     <= w_cnt_nx;
            r_stable  <= w_stable_nx;
            r_extinct <= w_extinct_nx;
            r_done    <= w_done_nx;
        end
    end

    always_comb begin
        w_state_nx   = r_state;
        w_board_nx   = r_board;
        w_cnt_nx     = r_cnt;
        w_stable_nx  = r_stable;
        w_extinct_nx = r_extinct;
        w_done_nx    = 1'b0;
        w_adv        = 1'b0;

        if (clear) begin
            w_state_nx   = IDLE;
            w_board_nx   = '0;
            w_cnt_nx     = '0;
            w_stable_nx  = 1'b0;
            w_extinct_nx = 1'b0;
        end else begin
            case (r_state)
                IDLE, HALT: begin
                    if (load) begin
                        w_state_nx   = IDLE;
                        w_board_nx   = seed;
                        w_cnt_nx     = '0;
                        w_stable_nx  = 1'b0;
                        w_extinct_nx = (seed == '0);
                    end else if (stop) begin
                        // Nothing to pause; stop just masks start/step.
                        w_state_nx = r_state;
                    end else if (start) begin
                        w_state_nx = RUN;
                    end else if (step) begin
                        w_state_nx = STEP;
                    end
                end
                STEP: begin
                    w_adv      = 1'b1;
                    w_state_nx = HALT;
                    w_done_nx  = 1'b1;
                end
                RUN: begin
                    // load is ignored while running.
                    if (stop) begin
                        w_state_nx = HALT;
                    end else begin
                        w_adv = 1'b1;
                    end
                end
                default: w_state_nx = IDLE;
            endcase

            if (w_adv) begin
                if (w_next == r_board) begin
                    // Board is a still life: freeze and report.
                    w_stable_nx = 1'b1;
                    w_done_nx   = 1'b1;
                    w_state_nx  = HALT;
                end else begin
                    w_board_nx   = w_next;
                    w_cnt_nx     = w_cnt_inc;
                    w_extinct_nx = (w_next == '0);
                    if ((w_next == '0) ||
                        ((max_gens != '0) && (w_cnt_inc == max_gens))) begin
                        w_done_nx  = 1'b1;
                        w_state_nx = HALT;
                    end
                end
            end
        end
    end

    assign gout      = r_board;
    assign gen_count = r_cnt;
    assign busy      = (r_state == RUN);
    assign done      = r_done;
    assign stable    = r_stable;
    assign extinct   = r_extinct;

endmodule
`default_nettype wire

// File: tb/tb_life_gen_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_life_gen_ctrl
//  Description : Self-checking bench for life_gen_ctrl (8x8, WRAP=0 and a
//                WRAP=1 instance sharing the same controls). Directed cases
//                plus randomised runs against a scatter-count reference.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_life_gen_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        clear;
    logic        load;
    logic [63:0] seed;
    logic        start;
    logic        step;
    logic        stop;
    logic [15:0] max_gens;

    logic [63:0] gout,    gout_w;
    logic [15:0] gen_count, gen_count_w;
    logic        busy, done, stable, extinct;
    logic        busy_w, done_w, stable_w, extinct_w;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    life_gen_ctrl #(.ROWS(8), .COLS(8), .GENW(16), .WRAP(0)) dut (
        .clk(clk), .reset(reset), .clear(clear), .load(load), .seed(seed),
        .start(start), .step(step), .stop(stop), .max_gens(max_gens),
        .gout(gout), .gen_count(gen_count), .busy(busy), .done(done),
        .stable(stable), .extinct(extinct)
    );

    life_gen_ctrl #(.ROWS(8), .COLS(8), .GENW(16), .WRAP(1)) dut_w (
        .clk(clk), .reset(reset), .clear(clear), .load(load), .seed(seed),
        .start(start), .step(step), .stop(stop), .max_gens(max_gens),
        .gout(gout_w), .gen_count(gen_count_w), .busy(busy_w), .done(done_w),
        .stable(stable_w), .extinct(extinct_w)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: every live cell adds one to each of its neighbours.
    function automatic logic [63:0] life(input logic [63:0] b, input bit wrap);
        int          cnt [8][8];
        int          nr, nc;
        logic [63:0] res;
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++)
                cnt[r][c] = 0;
        for (int r = 0; r < 8; r++) begin
            for (int c = 0; c < 8; c++) begin
                if (b[r*8+c]) begin
                    for (int dr = -1; dr <= 1; dr++) begin
                        for (int dc = -1; dc <= 1; dc++) begin
                            nr = r + dr;
                            nc = c + dc;
                            if (wrap) begin
                                nr = (nr + 8) % 8;
                                nc = (nc + 8) % 8;
                            end
                            if ((dr != 0 || dc != 0) && nr >= 0 && nr < 8 && nc >= 0 && nc < 8)
                                cnt[nr][nc] += 1;
                        end
                    end
                end
            end
        end
        res = '0;
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++)
                res[r*8+c] = (cnt[r][c] == 3) || (cnt[r][c] == 2 && b[r*8+c]);
        return res;
    endfunction

    // Outcome of a run from a freshly loaded seed.
    task automatic model_run(input logic [63:0] s, input int mg,
                             output logic [63:0] b, output int cnt,
                             output bit st, output bit ex);
        logic [63:0] n;
        b   = s;
        cnt = 0;
        st  = 0;
        ex  = (s == 0);
        forever begin
            n = life(b, 1'b0);
            if (n == b) begin
                st = 1;
                break;
            end
            b   = n;
            cnt = cnt + 1;
            ex  = (b == 0);
            if (b == 0) break;
            if (mg != 0 && cnt == mg) break;
        end
    endtask

    task automatic do_load(input logic [63:0] s);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        load  = 1'b1;
        seed  = s;
        tick();
        load  = 1'b0;
    endtask

    task automatic do_step();
        step = 1'b1;
        tick();
        step = 1'b0;
        tick();
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        bit ok;
        ok = 0;
        for (int i = 0; i < 300; i++) begin
            tick();
            if (done) begin
                ok = 1;
                break;
            end
        end
        check(tag, 64'(ok), 64'd1);
    endtask

    localparam logic [63:0] C_BLINK_H = 64'h0000_0000_1C00_0000;
    localparam logic [63:0] C_BLINK_V = 64'h0000_0008_0808_0000;

    logic [63:0] s, eb, ebw, tmp;
    int          ecnt, ecnt_w, mg;
    bit          est, eex;

    initial begin
        reset = 1'b1; clear = 1'b0; load = 1'b0; seed = '0;
        start = 1'b0; step = 1'b0; stop = 1'b0; max_gens = '0;
        tick(); tick();
        reset = 1'b0;
        tick();
        check("rst_gout",  gout, 64'd0);
        check("rst_cnt",   64'(gen_count), 64'd0);
        check("rst_flags", {60'd0, busy, done, stable, extinct}, 64'd0);

        // Blinker single steps
        do_load(C_BLINK_H);
        check("blink_load", gout, C_BLINK_H);
        do_step();
        check("blink_s1_gout", gout, C_BLINK_V);
        check("blink_s1_cnt",  64'(gen_count), 64'd1);
        check("blink_s1_done", 64'(done), 64'd1);
        tick();
        check("blink_done_pulse", 64'(done), 64'd0);
        do_step();
        check("blink_s2_gout", gout, C_BLINK_H);
        check("blink_s2_cnt",  64'(gen_count), 64'd2);

        // Block still life
        do_load(64'h303);
        do_start();
        wait_done("block_timeout");
        check("block_gout",   gout, 64'h303);
        check("block_stable", 64'(stable), 64'd1);
        check("block_cnt",    64'(gen_count), 64'd0);
        check("block_busy",   64'(busy), 64'd0);
        // Restart with stable set: re-detects and halts again
        do_start();
        check("block_rerun_busy", 64'(busy), 64'd1);
        wait_done("block_rerun_timeout");
        check("block_rerun_cnt", 64'(gen_count), 64'd0);

        // Bounded run
        do_load(C_BLINK_H);
        max_gens = 16'd5;
        do_start();
        wait_done("bound_timeout");
        check("bound_cnt",  64'(gen_count), 64'd5);
        check("bound_gout", gout, C_BLINK_V);
        check("bound_busy", 64'(busy), 64'd0);
        tick();
        check("bound_hold", 64'(gen_count), 64'd5);

        // Extinction
        max_gens = 16'd0;
        do_load(64'h1);
        do_start();
        wait_done("ext_timeout");
        check("ext_gout", gout, 64'd0);
        check("ext_flag", 64'(extinct), 64'd1);
        check("ext_cnt",  64'(gen_count), 64'd1);

        // Stop at generation 3
        do_load(C_BLINK_H);
        do_start();
        tick(); tick(); tick();
        check("stop_pre_cnt", 64'(gen_count), 64'd3);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        check("stop_cnt",  64'(gen_count), 64'd3);
        check("stop_busy", 64'(busy), 64'd0);
        check("stop_done", 64'(done), 64'd0);
        tick();
        check("stop_hold_cnt", 64'(gen_count), 64'd3);
        check("stop_gout", gout, C_BLINK_V);

        // Resume, then asynchronous reset mid-run
        do_start();
        tick();
        check("resume_cnt", 64'(gen_count), 64'd4);
        #2;
        reset = 1'b1;
        #1;
        check("areset_gout", gout, 64'd0);
        check("areset_cnt",  64'(gen_count), 64'd0);
        check("areset_flags", {60'd0, busy, done, stable, extinct}, 64'd0);
        tick();
        reset = 1'b0;

        // Clear mid-run
        do_load(C_BLINK_H);
        do_start();
        tick(); tick();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check("clear_gout", gout, 64'd0);
        check("clear_cnt",  64'(gen_count), 64'd0);
        check("clear_flags", {60'd0, busy, done, stable, extinct}, 64'd0);

        // Toroidal wrap
        tmp = '0;
        tmp[56] = 1'b1; tmp[0] = 1'b1; tmp[8] = 1'b1;
        do_load(tmp);
        do_step();
        check("wrap_gout",   gout_w, 64'h83);
        check("wrap_cnt",    64'(gen_count_w), 64'd1);
        check("nowrap_gout", gout, life(tmp, 1'b0));
        check("nowrap_ext",  64'(extinct), 64'(life(tmp, 1'b0) == 0));

        // Random bounded runs
        for (int t = 0; t < 8; t++) begin
            s  = {$urandom, $urandom} & {$urandom, $urandom};
            mg = $urandom_range(1, 30);
            model_run(s, mg, eb, ecnt, est, eex);
            do_load(s);
            max_gens = 16'(mg);
            do_start();
            wait_done("rnd_timeout");
            check("rnd_gout",    gout, eb);
            check("rnd_cnt",     64'(gen_count), 64'(ecnt));
            check("rnd_stable",  64'(stable), 64'(est));
            check("rnd_extinct", 64'(extinct), 64'(eex));
            check("rnd_busy",    64'(busy), 64'd0);
        end
        max_gens = '0;

        // Random single-step sequences on both edge modes
        for (int t = 0; t < 4; t++) begin
            s = {$urandom, $urandom} & {$urandom, $urandom};
            do_load(s);
            eb = s; ebw = s; ecnt = 0; ecnt_w = 0;
            for (int k = 0; k < 4; k++) begin
                tmp = life(eb, 1'b0);
                if (tmp != eb) begin eb = tmp; ecnt++; end
                tmp = life(ebw, 1'b1);
                if (tmp != ebw) begin ebw = tmp; ecnt_w++; end
                do_step();
                check("rstep_gout",   gout, eb);
                check("rstep_cnt",    64'(gen_count), 64'(ecnt));
                check("rstep_done",   64'(done), 64'd1);
                check("rstep_gout_w", gout_w, ebw);
                check("rstep_cnt_w",  64'(gen_count_w), 64'(ecnt_w));
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
